proc_pipe: RTL

- Parametrised successor to the 8-bit AND/ADD datapath processor.
- Accepts one packed instruction per clock with a valid qualifier. Each instruction carries an opcode, a storage address and two operands.
- Runs the instruction through a 3-stage register pipeline (capture, execute/write-back, output), writes ALU results into an internal storage array and presents them on y.
- Adds SUB/OR/XOR/LOAD operations, an explicit valid handshake and synchronous reset.

---
 rtl/proc_pipe.sv | 137 +++++++++++++
 1 files changed

// File: rtl/proc_pipe.sv
// proc_pipe: 3-stage AND/ADD/SUB/OR/XOR/LOAD pipeline with internal word storage.
// Optional carry/zero result flags are enabled by defining PROC_PIPE_FLAGS_EN.
module proc_pipe #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    localparam int INSTR_W = 3 + ADDR_W + 2 * DATA_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [INSTR_W-1:0] instr,
    output logic               out_valid,
`ifdef PROC_PIPE_FLAGS_EN
    output logic [DATA_W-1:0]  y,
    output logic               cout,
    output logic               zero
`else
    output logic [DATA_W-1:0]  y
`endif
);

    localparam int STAGES = 3;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_ADD  = 3'b001,
        OP_SUB  = 3'b010,
        OP_OR   = 3'b011,
        OP_XOR  = 3'b100,
        OP_LOAD = 3'b101,
        OP_NOP0 = 3'b110,
        OP_NOP1 = 3'b111
    } op_t;

    typedef struct packed {
        op_t               op;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } req_t;

    req_t              dec;
    req_t              s1;
    logic              accept;
    logic [STAGES:1]   vld_pipe;

    logic [DATA_W-1:0] mem [0:DEPTH-1];
    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   diff;
    logic [DATA_W-1:0] r;
    logic              c;
    logic [DATA_W-1:0] r2;
    logic              c2;

    assign dec    = req_t'(instr);
    // Both NOP encodings share the top two opcode bits.
    assign accept = in_valid && (dec.op[2:1] != 2'b11);

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:1], accept};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            s1 <= dec;
        end
    end

    assign sum  = {1'b0, s1.a} + {1'b0, s1.b};
    assign diff = {1'b0, s1.a} - {1'b0, s1.b};

    always_comb begin
        r = '0;
        c = 1'b0;
        case (s1.op)
            OP_AND:  r = s1.a & s1.b;
            OP_ADD: begin
                r = sum[DATA_W-1:0];
                c = sum[DATA_W];
            end
            // The extra diff bit is the borrow; carry means no borrow (a >= b).
            OP_SUB: begin
                r = diff[DATA_W-1:0];
                c = ~diff[DATA_W];
            end
            OP_OR:   r = s1.a | s1.b;
            OP_XOR:  r = s1.a ^ s1.b;
            OP_LOAD: r = mem[s1.addr];
            default: r = '0;
        endcase
    end

    // Write lands on the S2 edge, so a LOAD one cycle behind already sees it.
    always_ff @(posedge clk) begin
        if (!rst && vld_pipe[1] && (s1.op != OP_LOAD)) begin
            mem[s1.addr] <= r;
        end
    end

    always_ff @(posedge clk) begin
        if (vld_pipe[1]) begin
            r2 <= r;
            c2 <= c;
        end
    end

    assign out_valid = vld_pipe[STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            y <= '0;
        end else if (vld_pipe[2]) begin
            y <= r2;
        end
    end

`ifdef PROC_PIPE_FLAGS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cout <= 1'b0;
            zero <= 1'b0;
        end else if (vld_pipe[2]) begin
            cout <= c2;
            zero <= (r2 == '0);
        end
    end
`else
    logic unused_c2;
    assign unused_c2 = c2;
`endif

endmodule
